// File: rtl/regfile_pkg.sv
// Shared datapath constants and types for the general-purpose register file.
package regfile_pkg;
  localparam int WIDTH   = 16;
  localparam int REGBITS = 4;
  localparam int NREGS   = 2 ** REGBITS;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [REGBITS-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard_pend.sv
// Pending-result scoreboard: one bit per register, population count, and
// read-hazard lookup for the operand addresses presented this cycle.
module pend_scoreboard #(
  parameter int REGBITS  = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter int CNTBITS  = REGBITS + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pend_set,
  input  logic [REGBITS-1:0] pend_addr,
  input  logic               wr_en,
  input  logic [REGBITS-1:0] wr_addr,
  input  logic               rd_en,
  input  logic [REGBITS-1:0] rd_addr_a,
  input  logic [REGBITS-1:0] rd_addr_b,
  output logic               hazard,
  output logic [CNTBITS-1:0] pend_cnt
);
  localparam int NREGS = 2 ** REGBITS;

  logic [NREGS-1:0]   pending;
  logic [NREGS-1:0]   pendingNext;
  logic [NREGS-1:0]   setVec;
  logic [NREGS-1:0]   clrVec;
  logic               setValid;
  logic               incr;
  logic               decr;
  logic [CNTBITS-1:0] cntNext;
  logic               hitA;
  logic               hitB;

  // Next pending vector and count; a set and clear on the same register leaves it pending.
  always_comb begin
    setVec   = {NREGS{1'b0}};
    clrVec   = {NREGS{1'b0}};
    setValid = pend_set & ~(ZERO_REG & (pend_addr == {REGBITS{1'b0}}));
    if (setValid) begin
      setVec[pend_addr] = 1'b1;
    end else begin
      setVec = {NREGS{1'b0}};
    end
    if (wr_en) begin
      clrVec[wr_addr] = 1'b1;
    end else begin
      clrVec = {NREGS{1'b0}};
    end
    pendingNext = (pending & ~clrVec) | setVec;
    incr        = setValid & ~pending[pend_addr];
    decr        = wr_en & pending[wr_addr] & ~setVec[wr_addr];
    cntNext     = pend_cnt + {{(CNTBITS-1){1'b0}}, incr} - {{(CNTBITS-1){1'b0}}, decr};
  end

  // Pending vector and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= {NREGS{1'b0}};
      pend_cnt <= {CNTBITS{1'b0}};
    end else begin
      pending  <= pendingNext;
      pend_cnt <= cntNext;
    end
  end

  // A same-cycle write is forwarded by the bypass, so it masks the hazard.
  always_comb begin
    hitA   = pending[rd_addr_a] & ~(wr_en & (wr_addr == rd_addr_a));
    hitB   = pending[rd_addr_b] & ~(wr_en & (wr_addr == rd_addr_b));
    hazard = rd_en & (hitA | hitB);
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass, optional
// hardwired-zero r0 and a pending-result scoreboard.
module regfile_scoreboard #(
  parameter int WIDTH    = regfile_pkg::WIDTH,
  parameter int REGBITS  = regfile_pkg::REGBITS,
  parameter bit ZERO_REG = 1'b0,
  parameter int CNTBITS  = REGBITS + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  input  logic [REGBITS-1:0] rd_addr_a,
  input  logic [REGBITS-1:0] rd_addr_b,
  output logic [WIDTH-1:0]   rd_data_a,
  output logic [WIDTH-1:0]   rd_data_b,
  input  logic               wr_en,
  input  logic [REGBITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               pend_set,
  input  logic [REGBITS-1:0] pend_addr,
  output logic               hazard,
  output logic [CNTBITS-1:0] pend_cnt
);
  import regfile_pkg::*;

  localparam int NREGS = 2 ** REGBITS;

  logic [WIDTH-1:0] regArray [NREGS];
  logic             wrValid;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;

  // Operand selection: hardwired zero first, then bypass, then stored value.
  always_comb begin
    wrValid = wr_en & ~(ZERO_REG & (wr_addr == {REGBITS{1'b0}}));
    if (ZERO_REG && (rd_addr_a == {REGBITS{1'b0}})) begin
      valA = {WIDTH{1'b0}};
    end else if (wrValid && (wr_addr == rd_addr_a)) begin
      valA = wr_data;
    end else begin
      valA = regArray[rd_addr_a];
    end
    if (ZERO_REG && (rd_addr_b == {REGBITS{1'b0}})) begin
      valB = {WIDTH{1'b0}};
    end else if (wrValid && (wr_addr == rd_addr_b)) begin
      valB = wr_data;
    end else begin
      valB = regArray[rd_addr_b];
    end
  end

  // Register array and read-data registers; reset wipes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regArray[i] <= {WIDTH{1'b0}};
      end
      rd_data_a <= {WIDTH{1'b0}};
      rd_data_b <= {WIDTH{1'b0}};
    end else begin
      if (wrValid) begin
        regArray[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data_a <= valA;
        rd_data_b <= valB;
      end
    end
  end

  pend_scoreboard #(
    .REGBITS  (REGBITS),
    .ZERO_REG (ZERO_REG),
    .CNTBITS  (CNTBITS)
  ) uPend (
    .clk       (clk),
    .reset     (reset),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .hazard    (hazard),
    .pend_cnt  (pend_cnt)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: one instance with r0 ordinary, one with hardwired-zero r0, shared stimulus.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset, rd_en, wr_en, pend_set;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, pend_addr;
  logic [15:0] wr_data;
  logic [15:0] rdA0, rdB0, rdAZ, rdBZ;
  logic        haz0, hazZ;
  logic [4:0]  cnt0, cntZ;

  int total = 0;
  int bad   = 0;

  typedef struct {logic [15:0] a0; logic [15:0] b0; logic [15:0] aZ; logic [15:0] bZ;} exp_t;
  exp_t        q[$];
  logic [15:0] m0 [16];
  logic [15:0] mZ [16];
  logic [15:0] p0, pZ;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(16), .REGBITS(4), .ZERO_REG(1'b0), .CNTBITS(5)) dut0 (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rdA0), .rd_data_b(rdB0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .hazard(haz0), .pend_cnt(cnt0));

  regfile_scoreboard #(.WIDTH(16), .REGBITS(4), .ZERO_REG(1'b1), .CNTBITS(5)) dutZ (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rdAZ), .rd_data_b(rdBZ), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .hazard(hazZ), .pend_cnt(cntZ));

  function automatic logic [15:0] rv0(input logic [3:0] a);
    if (wr_en && wr_addr == a) return wr_data;
    return m0[a];
  endfunction

  function automatic logic [15:0] rvZ(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (wr_en && wr_addr == a) return wr_data;
    return mZ[a];
  endfunction

  function automatic logic expHaz(input logic [15:0] p);
    return rd_en && ((p[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a)) ||
                     (p[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b)));
  endfunction

  function automatic exp_t popExp();
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    return e;
  endfunction

  task automatic idle();
    reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0; pend_set = 1'b0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0; wr_addr = 4'd0; pend_addr = 4'd0; wr_data = 16'h0000;
  endtask

  // Push expected read data, advance one edge, then advance the reference model.
  task automatic tick();
    exp_t e;
    if (!reset && rd_en) begin
      e.a0 = rv0(rd_addr_a); e.b0 = rv0(rd_addr_b);
      e.aZ = rvZ(rd_addr_a); e.bZ = rvZ(rd_addr_b);
      q.push_back(e);
    end
    @(posedge clk); #1;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin m0[i] = 16'h0000; mZ[i] = 16'h0000; end
      p0 = 16'h0000; pZ = 16'h0000;
    end else begin
      if (wr_en) begin
        m0[wr_addr] = wr_data; p0[wr_addr] = 1'b0;
        if (wr_addr != 4'd0) begin mZ[wr_addr] = wr_data; pZ[wr_addr] = 1'b0; end
      end
      if (pend_set) begin
        p0[pend_addr] = 1'b1;
        if (pend_addr != 4'd0) pZ[pend_addr] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    idle(); reset = 1'b1; tick();
    idle(); rd_en = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd7; #1;
    total++; if (haz0 !== 1'b0) begin bad++; $display("FAIL reset_hazard got %b want 0", haz0); end
    tick(); e = popExp();
    total++; if (rdA0 !== e.a0) begin bad++; $display("FAIL reset_rdA got %h want %h", rdA0, e.a0); end
    total++; if (rdB0 !== 16'h0000) begin bad++; $display("FAIL reset_rdB got %h want 0000", rdB0); end
    total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", cnt0); end
    total++; if (cntZ !== 5'd0) begin bad++; $display("FAIL reset_cntZ got %0d want 0", cntZ); end
  endtask

  task automatic test_write_read();
    exp_t e;
    idle(); wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234; tick();
    idle(); rd_en = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd9; tick(); e = popExp();
    total++; if (rdA0 !== 16'h1234) begin bad++; $display("FAIL write_read got %h want 1234", rdA0); end
    total++; if (rdBZ !== e.bZ) begin bad++; $display("FAIL write_readB got %h want %h", rdBZ, e.bZ); end
    idle(); rd_addr_a = 4'd7; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h4321; tick();
    total++; if (rdA0 !== 16'h1234) begin bad++; $display("FAIL read_hold got %h want 1234", rdA0); end
    total++; if (rdAZ !== 16'h1234) begin bad++; $display("FAIL read_holdZ got %h want 1234", rdAZ); end
  endtask

  task automatic test_bypass();
    exp_t e;
    idle(); wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hBEEF; rd_en = 1'b1; rd_addr_a = 4'd9; rd_addr_b = 4'd5;
    tick(); e = popExp();
    total++; if (rdA0 !== 16'hBEEF) begin bad++; $display("FAIL bypass got %h want beef", rdA0); end
    total++; if (rdAZ !== e.aZ) begin bad++; $display("FAIL bypassZ got %h want %h", rdAZ, e.aZ); end
    total++; if (rdB0 !== e.b0) begin bad++; $display("FAIL bypass_otherB got %h want %h", rdB0, e.b0); end
    idle(); wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_en = 1'b1;
    tick(); e = popExp();
    total++; if (rdA0 !== e.a0) begin bad++; $display("FAIL bypass_r0 got %h want %h", rdA0, e.a0); end
    total++; if (rdAZ !== 16'h0000) begin bad++; $display("FAIL zero_bypass_r0 got %h want 0000", rdAZ); end
    idle(); rd_en = 1'b1; tick(); e = popExp();
    total++; if (rdAZ !== e.aZ) begin bad++; $display("FAIL zero_r0_stored got %h want %h", rdAZ, e.aZ); end
    total++; if (rdB0 !== 16'hFFFF) begin bad++; $display("FAIL r0_stored got %h want ffff", rdB0); end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    idle(); pend_set = 1'b1; pend_addr = 4'd2; tick();
    total++; if (cnt0 !== 5'd1) begin bad++; $display("FAIL pend_cnt_set got %0d want 1", cnt0); end
    idle(); rd_en = 1'b1; rd_addr_a = 4'd2; rd_addr_b = 4'd3; #1;
    total++; if (haz0 !== 1'b1) begin bad++; $display("FAIL hazard_pending got %b want 1", haz0); end
    total++; if (hazZ !== 1'b1) begin bad++; $display("FAIL hazardZ_pending got %b want 1", hazZ); end
    tick(); e = popExp();
    idle(); wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h00AA; rd_en = 1'b1; rd_addr_a = 4'd2; #1;
    total++; if (haz0 !== 1'b0) begin bad++; $display("FAIL hazard_bypass got %b want 0", haz0); end
    tick(); e = popExp();
    total++; if (rdA0 !== e.a0) begin bad++; $display("FAIL retire_data got %h want %h", rdA0, e.a0); end
    total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL pend_cnt_clear got %0d want 0", cnt0); end
  endtask

  task automatic test_set_clear_same();
    exp_t e;
    idle(); pend_set = 1'b1; pend_addr = 4'd4; tick();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0011; tick();
    total++; if (cnt0 !== 5'd1) begin bad++; $display("FAIL set_wins_cnt got %0d want 1", cnt0); end
    idle(); rd_en = 1'b1; rd_addr_a = 4'd4; rd_addr_b = 4'd4; #1;
    total++; if (haz0 !== 1'b1) begin bad++; $display("FAIL set_wins_hazard got %b want 1", haz0); end
    tick(); e = popExp();
    total++; if (rdA0 !== 16'h0011) begin bad++; $display("FAIL set_wins_data got %h want 0011", rdA0); end
    idle(); pend_set = 1'b1; pend_addr = 4'd0; tick();
    total++; if (cnt0 !== 5'd2) begin bad++; $display("FAIL pend_r0_cnt got %0d want 2", cnt0); end
    total++; if (cntZ !== 5'd1) begin bad++; $display("FAIL zero_pend_r0_cnt got %0d want 1", cntZ); end
    pend_addr = 4'd4; tick();
    total++; if (cnt0 !== 5'd2) begin bad++; $display("FAIL repend_cnt got %0d want 2", cnt0); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    idle(); reset = 1'b1; tick();
    for (int i = 1; i <= 3; i++) begin idle(); pend_set = 1'b1; pend_addr = 4'(i); tick(); end
    total++; if (cnt0 !== 5'd3) begin bad++; $display("FAIL three_pending got %0d want 3", cnt0); end
    idle(); wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h5555; tick();
    idle(); reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777;
    pend_set = 1'b1; pend_addr = 4'd8; rd_en = 1'b1; rd_addr_a = 4'd6; rd_addr_b = 4'd6; tick();
    total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL midreset_cnt got %0d want 0", cnt0); end
    total++; if (rdA0 !== 16'h0000) begin bad++; $display("FAIL midreset_rdA got %h want 0000", rdA0); end
    idle(); rd_en = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd6; #1;
    total++; if (haz0 !== 1'b0) begin bad++; $display("FAIL midreset_hazard got %b want 0", haz0); end
    tick(); e = popExp();
    total++; if (rdB0 !== 16'h0000) begin bad++; $display("FAIL midreset_r6 got %h want 0000", rdB0); end
    idle(); rd_en = 1'b1; rd_addr_a = 4'd7; rd_addr_b = 4'd8; #1;
    total++; if (haz0 !== 1'b0) begin bad++; $display("FAIL reset_pend_discard got %b want 0", haz0); end
    tick(); e = popExp();
    total++; if (rdA0 !== e.a0) begin bad++; $display("FAIL reset_wr_discard got %h want %h", rdA0, e.a0); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int n = 0; n < 80; n++) begin
      idle();
      rd_en = 1'($urandom_range(0, 1)); wr_en = 1'($urandom_range(0, 1));
      pend_set = ($urandom_range(0, 2) == 0);
      rd_addr_a = 4'($urandom_range(0, 7)); rd_addr_b = 4'($urandom_range(0, 7));
      wr_addr = 4'($urandom_range(0, 7)); pend_addr = 4'($urandom_range(0, 7));
      wr_data = 16'($urandom());
      #1;
      total++; if (haz0 !== expHaz(p0)) begin bad++; $display("FAIL b2b_hazard n=%0d got %b want %b", n, haz0, expHaz(p0)); end
      total++; if (hazZ !== expHaz(pZ)) begin bad++; $display("FAIL b2b_hazardZ n=%0d got %b want %b", n, hazZ, expHaz(pZ)); end
      tick();
      if (q.size() > 0) begin
        e = popExp();
        total++; if (rdA0 !== e.a0 || rdB0 !== e.b0) begin bad++; $display("FAIL b2b_read n=%0d got %h/%h want %h/%h", n, rdA0, rdB0, e.a0, e.b0); end
        total++; if (rdAZ !== e.aZ || rdBZ !== e.bZ) begin bad++; $display("FAIL b2b_readZ n=%0d got %h/%h want %h/%h", n, rdAZ, rdBZ, e.aZ, e.bZ); end
      end
      total++; if (cnt0 !== 5'($countones(p0))) begin bad++; $display("FAIL b2b_cnt n=%0d got %0d want %0d", n, cnt0, $countones(p0)); end
      total++; if (cntZ !== 5'($countones(pZ))) begin bad++; $display("FAIL b2b_cntZ n=%0d got %0d want %0d", n, cntZ, $countones(pZ)); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_set_clear_same();
    test_reset_mid();
    test_back_to_back();
    total++; if (q.size() != 0) begin bad++; $display("FAIL queue_drain got %0d want 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
